seg_scan_ctrl: RTL and testbench
================================

Name: seg_scan_ctrl

Overview:
Upstream feeder for the per-digit 7-segment decoder. It takes ASCII bytes from the UART receiver and maintains an NUM_DIGITS-wide hex digit buffer. It commits that buffer to a display shadow only at frame boundaries, so a partial edit is never shown. It time-multiplexes the shadow onto one 4-bit num bus plus active-low digit selects, with the selects pipelined to match the decoder's one-cycle registered latency.

Parameters:
NUM_DIGITS, 4, number of multiplexed digits (>=2)
SCAN_DIV, 50000, clk cycles per digit slot (> DEAD_CYCLES+2)
DEAD_CYCLES, 2, anti-ghosting blank cycles at the start of each slot

Ports:
clk  in  1  clock
rst  in  1  reset, synchronous, active-low
rx_data  in  8  received ASCII byte
rx_valid  in  1  rx_data valid
rx_ready  out  1  byte accepted when rx_valid && rx_ready
num  out  4  digit value to the 7-seg decoder
digit_sel  out  NUM_DIGITS  active-low one-hot digit enable, aligned to decoder output
frame_tick  out  1  1-cycle pulse at every frame boundary
bad_char  out  1  1-cycle pulse when an accepted byte is unrecognised

Behaviour:
- Reset (rst==0 sampled at posedge):
  - edit_buf, disp_buf, dirty, prescaler cnt, digit index idx all 0.
  - Outputs: num=0, digit_sel=all 1s, rx_ready=0, frame_tick=0, bad_char=0.
  - Pipeline stages are cleared as well.
- rx_ready is registered: it becomes 1 on the first posedge after rst releases and stays 1. One byte may be accepted per cycle.
- Digit numbering: digit 0 is the rightmost (least significant) digit.
- Byte decode on accept:
  - '0'-'9' (0x30-0x39), 'A'-'F' (0x41-0x46), 'a'-'f' (0x61-0x66): shift left. Digit k <= digit k-1, digit 0 <= the value, the top digit is discarded. dirty <= 1.
  - 0x08 (backspace): shift right. Digit k <= digit k+1, the top digit <= 0. dirty <= 1.
  - 0x1B (ESC): edit_buf <= 0. dirty <= 1.
  - Any other byte: edit_buf unchanged, bad_char pulses high on the next cycle.
- Prescaler:
  - cnt counts 0..SCAN_DIV-1. When cnt==SCAN_DIV-1, cnt <= 0 and idx advances.
  - idx wraps from NUM_DIGITS-1 to 0.
- Frame boundary is the cycle in which idx wraps to 0.
  - frame_tick is registered high in the following cycle.
  - If dirty, then disp_buf <= edit_buf and dirty <= 0.
- Accept coinciding with a frame boundary:
  - The commit uses edit_buf from before this cycle's update.
  - The new byte lands in edit_buf and dirty stays 1, so it is shown from the next frame.
- Scan pipeline:
  - Stage 1: num <= disp_buf digit[idx]; en1 <= (cnt >= DEAD_CYCLES); idx1 <= idx.
  - Stage 2: digit_sel <= en2 ? ~(1<<idx2) : all 1s, where en2/idx2 are en1/idx1 delayed one more cycle.
  - Result: digit_sel changes exactly when the decoder's segment output for that num is valid (2 cycles after the slot change).
  - Per slot, digit_sel is low for SCAN_DIV-DEAD_CYCLES cycles, starting DEAD_CYCLES+2 cycles after cnt returns to 0. At most one digit_sel bit is ever low.
- Reset mid-frame or mid-byte:
  - All state clears on that edge and the accepted byte is dropped.
  - Scanning restarts at idx=0 with cnt=0.

Test Plan:
(All scenarios use NUM_DIGITS=4, SCAN_DIV=8, DEAD_CYCLES=2.)
1. Hold rst=0 for 3 cycles, then release. Required: num=0, digit_sel=4'b1111 during reset. rx_ready=1 on the first cycle after release. The first low digit_sel is 4'b1110, 4 cycles after the slot start.
2. Send '1','2','3','4' on consecutive cycles. Required: after the next frame_tick, disp_buf=0x1234. Slot idx0 shows num=4 with digit_sel=4'b1110 for 6 cycles. Slot idx3 shows num=1 with digit_sel=4'b0111.
3. From 0x1234: send 'b', then 0x08, then 'G' (0x47), then ESC, committing a frame after each byte. Required committed values: 0x234B, then 0x0234, then unchanged with a single bad_char pulse, then 0x0000. Lowercase 'b' must map to 0xB.
4. Hold edit_buf=0x0000 and assert 'F' in the exact frame-boundary cycle. Required: that frame still shows 0x0000; 0x000F appears only after the following frame_tick.
5. Drive rst=0 in the middle of slot idx2 while digit_sel=4'b1011. Required: next cycle digit_sel=4'b1111, num=0, both buffers cleared; after release, scanning restarts at idx0.
6. Check every cycle over 3 frames. Required: digit_sel is never low on more than one bit, and frame_tick pulses exactly every 32 cycles.

Source files
------------

// File: rtl/seg_scan_ctrl.sv
// -----------------------------------------------------------------------------
// seg_scan_ctrl
//
// Purpose:
//   Feeds the per-digit 7-segment decoder. ASCII bytes from the UART receiver
//   edit a NUM_DIGITS-wide hex digit buffer (edit_buf). That buffer is copied to
//   a display shadow (disp_buf) only at frame boundaries, so a half-typed value
//   is never visible. The shadow is time-multiplexed onto a 4-bit num bus. The
//   active-low digit selects lag num by one extra register stage, which matches
//   the decoder's one-cycle registered latency.
//
// Ports:
//   clk         in   clock
//   rst         in   synchronous, active-low reset
//   rx_data     in   received ASCII byte
//   rx_valid    in   rx_data valid
//   rx_ready    out  byte accepted on a cycle with rx_valid && rx_ready
//   num         out  digit value to the 7-seg decoder
//   digit_sel   out  active-low one-hot digit enable, aligned to decoder output
//   frame_tick  out  1-cycle pulse after every frame boundary
//   bad_char    out  1-cycle pulse after an accepted, unrecognised byte
//
// Handshake: a byte transfers on every rising edge where rx_valid and rx_ready
// are both high. rx_ready does not depend on rx_valid. It is low only in reset
// and on the first cycle after reset, and high after that. One byte can be
// accepted every cycle.
// -----------------------------------------------------------------------------
module seg_scan_ctrl #(
    parameter int NUM_DIGITS  = 4,
    parameter int SCAN_DIV    = 50000,
    parameter int DEAD_CYCLES = 2
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic [7:0]            rx_data,
    input  logic                  rx_valid,
    output logic                  rx_ready,
    output logic [3:0]            num,
    output logic [NUM_DIGITS-1:0] digit_sel,
    output logic                  frame_tick,
    output logic                  bad_char
);

    localparam int CW = (SCAN_DIV > 1) ? $clog2(SCAN_DIV) : 1;
    localparam int IW = $clog2(NUM_DIGITS);
    localparam int BW = 4 * NUM_DIGITS;

    localparam logic [CW-1:0] CNT_LAST = CW'(SCAN_DIV - 1);
    localparam logic [CW-1:0] CNT_DEAD = CW'(DEAD_CYCLES);
    localparam logic [IW-1:0] IDX_LAST = IW'(NUM_DIGITS - 1);

    // ------------------------------------------------------------------
    // State
    // ------------------------------------------------------------------
    logic                  rdy_q;
    logic [CW-1:0]         cnt_q,   cnt_d;
    logic [IW-1:0]         idx_q,   idx_d;
    logic [BW-1:0]         edit_q,  edit_d;
    logic [BW-1:0]         disp_q,  disp_d;
    logic                  dirty_q, dirty_d;
    logic                  ftick_q, ftick_d;
    logic                  bad_q,   bad_d;

    // Scan pipeline: stage 1 (num, en1, idx1), stage 2 (digit_sel)
    logic [3:0]            num_q,   num_d;
    logic                  en1_q,   en1_d;
    logic [IW-1:0]         idx1_q,  idx1_d;
    logic [NUM_DIGITS-1:0] sel_q,   sel_d;

    // ------------------------------------------------------------------
    // Byte decode
    // ------------------------------------------------------------------
    logic       accept;
    logic       is_hex;
    logic       is_bs;
    logic       is_esc;
    logic [3:0] hex_val;

    assign accept = rx_valid && rdy_q;
    assign is_bs  = (rx_data == 8'h08);
    assign is_esc = (rx_data == 8'h1B);

    always_comb begin
        is_hex  = 1'b0;
        hex_val = 4'h0;
        if (rx_data >= 8'h30 && rx_data <= 8'h39) begin
            is_hex  = 1'b1;
            hex_val = rx_data[3:0];
        end else if ((rx_data >= 8'h41 && rx_data <= 8'h46) ||
                     (rx_data >= 8'h61 && rx_data <= 8'h66)) begin
            // 'A'/'a' have 1 in their low nibble, so adding 9 gives 0xA..0xF
            is_hex  = 1'b1;
            hex_val = rx_data[3:0] + 4'd9;
        end
    end

    // ------------------------------------------------------------------
    // Prescaler and digit index
    // ------------------------------------------------------------------
    logic slot_end;
    logic frame_bnd;

    assign slot_end  = (cnt_q == CNT_LAST);
    // The frame boundary is the last cycle of the last slot, which is the
    // cycle in which idx wraps back to 0.
    assign frame_bnd = slot_end && (idx_q == IDX_LAST);

    always_comb begin
        cnt_d = cnt_q + CW'(1);
        idx_d = idx_q;
        if (slot_end) begin
            cnt_d = '0;
            idx_d = (idx_q == IDX_LAST) ? '0 : idx_q + IW'(1);
        end
    end

    // ------------------------------------------------------------------
    // Edit buffer, dirty flag and commit to the display shadow
    // ------------------------------------------------------------------
    always_comb begin
        edit_d  = edit_q;
        dirty_d = dirty_q;
        bad_d   = 1'b0;
        // The commit clears dirty. An edit accepted in the same cycle sets it
        // again (assigned later, so it wins). The new byte then shows up in
        // the next frame.
        if (frame_bnd) begin
            dirty_d = 1'b0;
        end
        if (accept) begin
            if (is_hex) begin
                edit_d  = {edit_q[BW-5:0], hex_val};
                dirty_d = 1'b1;
            end else if (is_bs) begin
                edit_d  = {4'h0, edit_q[BW-1:4]};
                dirty_d = 1'b1;
            end else if (is_esc) begin
                edit_d  = '0;
                dirty_d = 1'b1;
            end else begin
                bad_d = 1'b1;
            end
        end
    end

    // The commit reads edit_q, which is the buffer as it was before this
    // cycle's edit.
    always_comb begin
        disp_d = disp_q;
        if (frame_bnd && dirty_q) begin
            disp_d = edit_q;
        end
    end

    assign ftick_d = frame_bnd;

    // ------------------------------------------------------------------
    // Scan pipeline
    // ------------------------------------------------------------------
    // Stage 1: pick the current digit from the shadow. Also record whether
    // this slot is past its blanking window, and which digit that is.
    always_comb begin
        num_d = 4'h0;
        for (int k = 0; k < NUM_DIGITS; k++) begin
            if (idx_q == IW'(k)) begin
                num_d = disp_q[4*k +: 4];
            end
        end
    end

    assign en1_d  = (cnt_q >= CNT_DEAD);
    assign idx1_d = idx_q;

    // Stage 2: this select changes in the same cycle that the decoder's
    // registered segments for stage-1 num become valid.
    always_comb begin
        sel_d = '1;
        if (en1_q) begin
            for (int k = 0; k < NUM_DIGITS; k++) begin
                if (idx1_q == IW'(k)) begin
                    sel_d[k] = 1'b0;
                end
            end
        end
    end

    // ------------------------------------------------------------------
    // Registers
    // ------------------------------------------------------------------
    always_ff @(posedge clk) begin
        if (!rst) begin
            rdy_q   <= 1'b0;
            cnt_q   <= '0;
            idx_q   <= '0;
            edit_q  <= '0;
            disp_q  <= '0;
            dirty_q <= 1'b0;
            ftick_q <= 1'b0;
            bad_q   <= 1'b0;
            num_q   <= 4'h0;
            en1_q   <= 1'b0;
            idx1_q  <= '0;
            sel_q   <= '1;
        end else begin
            rdy_q   <= 1'b1;
            cnt_q   <= cnt_d;
            idx_q   <= idx_d;
            edit_q  <= edit_d;
            disp_q  <= disp_d;
            dirty_q <= dirty_d;
            ftick_q <= ftick_d;
            bad_q   <= bad_d;
            num_q   <= num_d;
            en1_q   <= en1_d;
            idx1_q  <= idx1_d;
            sel_q   <= sel_d;
        end
    end

    // ------------------------------------------------------------------
    // Outputs
    // ------------------------------------------------------------------
    assign rx_ready   = rdy_q;
    assign num        = num_q;
    assign digit_sel  = sel_q;
    assign frame_tick = ftick_q;
    assign bad_char   = bad_q;

endmodule

// File: tb/tb_seg_scan_ctrl.sv
// -----------------------------------------------------------------------------
// tb_seg_scan_ctrl
//
// Self-checking bench for seg_scan_ctrl with NUM_DIGITS=4, SCAN_DIV=8 and
// DEAD_CYCLES=2. A timeline reference model predicts every output on every
// cycle. It works from the cycle number since reset and from arithmetic on the
// buffer values. Table vectors and directed sequences check what the display
// shows. The shown value is rebuilt by pairing each low digit_sel with the num
// the decoder held in that cycle (num from one cycle earlier).
// -----------------------------------------------------------------------------
module tb_seg_scan_ctrl;

    localparam int ND    = 4;
    localparam int SD    = 8;
    localparam int DC    = 2;
    localparam int FRAME = ND * SD;

    // ---------------- clock / reset / DUT ----------------
    logic          clk      = 1'b0;
    logic          rst      = 1'b0;
    logic [7:0]    rx_data  = 8'h00;
    logic          rx_valid = 1'b0;
    logic          rx_ready;
    logic [3:0]    num;
    logic [ND-1:0] digit_sel;
    logic          frame_tick;
    logic          bad_char;

    always #5 clk = ~clk;

    seg_scan_ctrl #(
        .NUM_DIGITS (ND),
        .SCAN_DIV   (SD),
        .DEAD_CYCLES(DC)
    ) dut (
        .clk       (clk),
        .rst       (rst),
        .rx_data   (rx_data),
        .rx_valid  (rx_valid),
        .rx_ready  (rx_ready),
        .num       (num),
        .digit_sel (digit_sel),
        .frame_tick(frame_tick),
        .bad_char  (bad_char)
    );

    initial begin
        #2000000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    // ---------------- bookkeeping ----------------
    int n_pass  = 0;
    int n_total = 0;
    int cyc     = 0;

    function automatic void chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_total++;
        if (act === exp) n_pass++;
        else $display("FAIL %s: got 0x%0h, expected 0x%0h (cycle %0d)", name, act, exp, cyc);
    endfunction

    // ---------------- reference model ----------------
    int         m_t;           // edges since the last reset edge
    logic [15:0] m_edit, m_disp;
    bit         m_dirty, m_rdy, m_bad, m_ft;
    logic [3:0] m_num;
    logic [3:0] m_sel;

    // Monitor state for display reconstruction and frame period
    logic [3:0] prev_num;
    logic [3:0] seg_num;
    logic [3:0] shown [ND];
    int         ft_prev_cyc = -1;

    logic [15:0] exp_q[$];

    function automatic bit char_hex(input logic [7:0] c, output int v);
        v = 0;
        if (c >= 8'h30 && c <= 8'h39) begin v = int'(c) - 48; return 1'b1; end
        if (c >= 8'h41 && c <= 8'h46) begin v = int'(c) - 65 + 10; return 1'b1; end
        if (c >= 8'h61 && c <= 8'h66) begin v = int'(c) - 97 + 10; return 1'b1; end
        return 1'b0;
    endfunction

    task automatic model_edge();
        int          old_t, s, hv;
        logic [15:0] old_edit, old_disp;
        logic [3:0]  one;
        bit          acc;
        one = 4'b0001;
        if (!rst) begin
            m_t = 0; m_edit = 16'h0; m_disp = 16'h0; m_dirty = 0;
            m_rdy = 0; m_bad = 0; m_ft = 0; m_num = 4'h0; m_sel = 4'hF;
            ft_prev_cyc = -1;
        end else begin
            old_t    = m_t;
            old_edit = m_edit;
            old_disp = m_disp;
            acc      = rx_valid && m_rdy;
            // num shows the digit scanned in the previous cycle
            m_num = 4'((int'(old_disp) >> (4 * ((old_t / SD) % ND))) % 16);
            m_t   = old_t + 1;
            // the select trails the slot counter by two cycles and is blank
            // during the first DC counts of each slot
            s = m_t - 2;
            if (s >= 0 && (s % SD) >= DC) m_sel = ~(one << ((s / SD) % ND));
            else                          m_sel = 4'hF;
            m_ft = ((old_t % FRAME) == FRAME - 1);
            if (m_ft && m_dirty) begin
                m_disp  = old_edit;
                m_dirty = 0;
            end
            m_bad = 0;
            if (acc) begin
                if (char_hex(rx_data, hv)) begin
                    m_edit  = 16'((int'(old_edit) * 16 + hv) % 65536);
                    m_dirty = 1;
                end else if (rx_data == 8'h08) begin
                    m_edit  = 16'(int'(old_edit) / 16);
                    m_dirty = 1;
                end else if (rx_data == 8'h1B) begin
                    m_edit  = 16'h0;
                    m_dirty = 1;
                end else begin
                    m_bad = 1;
                end
            end
            m_rdy = 1;
        end
    endtask

    function automatic void compare();
        chk("num",        32'(num),        32'(m_num));
        chk("digit_sel",  32'(digit_sel),  32'(m_sel));
        chk("rx_ready",   32'(rx_ready),   32'(m_rdy));
        chk("frame_tick", 32'(frame_tick), 32'(m_ft));
        chk("bad_char",   32'(bad_char),   32'(m_bad));
        chk("sel_onehot", 32'($countones(~digit_sel) <= 1), 32'd1);
        if (frame_tick === 1'b1) begin
            if (ft_prev_cyc >= 0) chk("frame_period", 32'(cyc - ft_prev_cyc), 32'(FRAME));
            ft_prev_cyc = cyc;
        end
        seg_num = prev_num;
        for (int k = 0; k < ND; k++) begin
            if (digit_sel[k] === 1'b0) shown[k] = seg_num;
        end
        prev_num = num;
    endfunction

    // ---------------- driver tasks ----------------
    task automatic tick();
        @(posedge clk);
        cyc++;
        model_edge();
        #1;
        compare();
    endtask

    task automatic send_byte(input logic [7:0] ch);
        rx_data  = ch;
        rx_valid = 1'b1;
        tick();
        rx_valid = 1'b0;
        rx_data  = 8'($urandom_range(0, 255));
    endtask

    task automatic wait_frame_tick();
        int n = 0;
        while (frame_tick !== 1'b1 && n < FRAME + 4) begin
            tick();
            n++;
        end
        chk("frame_tick_seen", 32'(frame_tick), 32'd1);
    endtask

    task automatic wait_sel(input logic [3:0] pat);
        int n = 0;
        while (digit_sel !== pat && n < 2 * FRAME + 4) begin
            tick();
            n++;
        end
        chk("wait_sel", 32'(digit_sel), 32'(pat));
    endtask

    task automatic wait_boundary();
        int n = 0;
        while ((m_t % FRAME) != FRAME - 1 && n < FRAME + 2) begin
            tick();
            n++;
        end
    endtask

    // Waits for the next commit, then rebuilds one full frame from the outputs
    task automatic observe_frame(input string name);
        logic [15:0] got;
        logic [15:0] exp;
        wait_frame_tick();
        for (int k = 0; k < ND; k++) shown[k] = 4'hx;
        repeat (FRAME + 2) tick();
        got = {shown[3], shown[2], shown[1], shown[0]};
        exp = exp_q.pop_front();
        chk(name, 32'(got), 32'(exp));
    endtask

    // After a reset release: ready at once, first select 4 cycles after slot start
    task automatic check_restart();
        int n;
        tick();
        chk("ready_after_release", 32'(rx_ready), 32'd1);
        n = 1;
        while (digit_sel === 4'hF && n < 20) begin
            tick();
            n++;
        end
        chk("first_sel_delay", 32'(n), 32'd4);
        chk("first_sel", 32'(digit_sel), 32'h0000000E);
    endtask

    function automatic logic [7:0] rand_byte();
        int r;
        int v;
        r = $urandom_range(0, 9);
        if (r <= 5) begin
            v = $urandom_range(0, 21);
            if (v < 10)      return 8'(48 + v);
            else if (v < 16) return 8'(65 + v - 10);
            else             return 8'(97 + v - 16);
        end
        if (r == 6) return 8'h08;
        if (r == 7) return 8'h1B;
        return 8'($urandom_range(0, 255));
    endfunction

    // ---------------- vector table ----------------
    typedef struct {
        logic [7:0]  ch;
        logic [15:0] exp_disp;
        logic        exp_bad;
    } vec_t;

    vec_t vecs[14];

    // ---------------- main sequence ----------------
    initial begin
        int n_ft;
        int slot_len;

        vecs[0]  = '{8'h62, 16'h234B, 1'b0};  // 'b'
        vecs[1]  = '{8'h08, 16'h0234, 1'b0};  // backspace
        vecs[2]  = '{8'h47, 16'h0234, 1'b1};  // 'G'
        vecs[3]  = '{8'h1B, 16'h0000, 1'b0};  // ESC
        vecs[4]  = '{8'h61, 16'h000A, 1'b0};  // 'a'
        vecs[5]  = '{8'h43, 16'h00AC, 1'b0};  // 'C'
        vecs[6]  = '{8'h35, 16'h0AC5, 1'b0};  // '5'
        vecs[7]  = '{8'h65, 16'hAC5E, 1'b0};  // 'e'
        vecs[8]  = '{8'h30, 16'hC5E0, 1'b0};  // '0'
        vecs[9]  = '{8'h20, 16'hC5E0, 1'b1};  // space
        vecs[10] = '{8'h08, 16'h0C5E, 1'b0};  // backspace
        vecs[11] = '{8'h67, 16'h0C5E, 1'b1};  // 'g', just past 'f'
        vecs[12] = '{8'h40, 16'h0C5E, 1'b1};  // '@', just below 'A'
        vecs[13] = '{8'h1B, 16'h0000, 1'b0};  // ESC

        // 1. reset and release
        rst = 1'b0;
        repeat (3) begin
            tick();
            chk("reset_num", 32'(num), 32'd0);
            chk("reset_sel", 32'(digit_sel), 32'h0000000F);
            chk("reset_rdy", 32'(rx_ready), 32'd0);
        end
        rst = 1'b1;
        check_restart();

        // 2. "1234" on back-to-back cycles
        send_byte(8'h31);
        send_byte(8'h32);
        send_byte(8'h33);
        send_byte(8'h34);
        exp_q.push_back(16'h1234);
        observe_frame("disp_1234");
        wait_sel(4'b1110);
        slot_len = 0;
        while (digit_sel === 4'b1110 && slot_len < 20) begin
            chk("slot0_num", 32'(seg_num), 32'd4);
            slot_len++;
            tick();
        end
        chk("slot0_len", 32'(slot_len), 32'(SD - DC));
        wait_sel(4'b0111);
        chk("slot3_num", 32'(seg_num), 32'd1);

        // 3. table: one byte per frame, check committed value and bad_char
        for (int i = 0; i < 14; i++) begin
            send_byte(vecs[i].ch);
            chk($sformatf("vec%0d_bad", i), 32'(bad_char), 32'(vecs[i].exp_bad));
            exp_q.push_back(vecs[i].exp_disp);
            observe_frame($sformatf("vec%0d_disp", i));
        end

        // 4. accept in the exact frame-boundary cycle
        wait_boundary();
        send_byte(8'h46);
        chk("boundary_tick", 32'(frame_tick), 32'd1);
        exp_q.push_back(16'h0000);
        observe_frame("boundary_old");
        exp_q.push_back(16'h000F);
        observe_frame("boundary_new");
        // the same case with a pending commit: '7' commits, '8' waits a frame
        send_byte(8'h37);
        wait_boundary();
        send_byte(8'h38);
        exp_q.push_back(16'h00F7);
        observe_frame("boundary_dirty_old");
        exp_q.push_back(16'h0F78);
        observe_frame("boundary_dirty_new");

        // 5. reset in slot idx2, together with a byte that must be dropped
        wait_sel(4'b1011);
        rst      = 1'b0;
        rx_valid = 1'b1;
        rx_data  = 8'h37;
        tick();
        chk("rst_mid_sel", 32'(digit_sel), 32'h0000000F);
        chk("rst_mid_num", 32'(num), 32'd0);
        rx_valid = 1'b0;
        rst      = 1'b1;
        check_restart();
        exp_q.push_back(16'h0000);
        observe_frame("after_rst_disp");
        send_byte(8'h35);
        exp_q.push_back(16'h0005);
        observe_frame("after_rst_edit");

        // 6. random traffic with occasional resets, checked by the model
        for (int i = 0; i < 600; i++) begin
            rst      = ($urandom_range(0, 299) == 0) ? 1'b0 : 1'b1;
            rx_valid = ($urandom_range(0, 2) == 0);
            rx_data  = rand_byte();
            tick();
        end
        rst      = 1'b1;
        rx_valid = 1'b0;
        n_ft     = 0;
        for (int i = 0; i < 3 * FRAME; i++) begin
            tick();
            if (frame_tick === 1'b1) n_ft++;
        end
        chk("ft_count_3frames", 32'(n_ft), 32'd3);

        $display("%0d/%0d checks passed", n_pass, n_total);
        $finish;
    end

endmodule
